systolic_feed_ctrl: RTL and testbench
=====================================

// Module: systolic_feed_ctrl
// PURPOSE
//  Sequencer for the NxN output-stationary integer systolic multiplier (multip).
//  - Accepts two NxN operand matrices in one start handshake.
//  - Clears the PE accumulators, then drives skewed rows of A onto the west edge and skewed columns of B onto the north edge.
//  - Waits for the array to drain, then captures the NxN result and holds it until the consumer accepts it.
// PARAMETERS
//  N      3  array dimension (rows = cols = inner dimension)
//  DW     5  operand width per element
//  ACC_W  5  result width per PE, as presented by the array
//  LAT    1  PE pipeline drain cycles after the last feed step (>=1)
// PORTS
//  clk          in   1          system clock, rising edge
//  rst_n        in   1          asynchronous active-low reset
//  start        in   1          job request; accepted when start && start_ready
//  start_ready  out  1          high only in IDLE
//  a_mat        in   N*N*DW     A[i][k] at bits [(i*N+k)*DW +: DW]
//  b_mat        in   N*N*DW     B[k][j] at bits [(k*N+j)*DW +: DW]
//  pe_clr       out  1          clear all PE accumulators
//  pe_en        out  1          array advance enable
//  a_feed       out  N*DW       west edge; row i at [i*DW +: DW]
//  b_feed       out  N*DW       north edge; column j at [j*DW +: DW]
//  arr_res      in   N*N*ACC_W  PE accumulators, C[i][j] at [(i*N+j)*ACC_W +: ACC_W]
//  res          out  N*N*ACC_W  captured result, same layout as arr_res
//  res_valid    out  1          res holds a completed job
//  res_ready    in   1          consumer accepts res
//  busy         out  1          high in every state except IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0):
//  - State goes to IDLE; start_ready=1.
//  - pe_clr, pe_en, a_feed, b_feed, res, res_valid and busy are all 0.
//  - A job in flight at reset is discarded.
//  States: IDLE -> CLEAR -> FEED -> DRAIN -> RESULT -> IDLE.
//  - IDLE: on start && start_ready, latch a_mat/b_mat into internal regs and go to CLEAR. No other state accepts start.
//  - CLEAR: 1 cycle; pe_clr=1, pe_en=0, feeds 0. Then FEED with step t=0.
//  - FEED: 3N-2 cycles, t = 0..3N-3; pe_en=1.
//    - a_feed[i] = A[i][t-i] when 0 <= t-i < N, else 0.
//    - b_feed[j] = B[t-j][j] when 0 <= t-j < N, else 0.
//  - DRAIN: LAT cycles; pe_en=1, feeds 0.
//  - RESULT: on entry, res <= arr_res and res_valid=1.
//    - res stays stable while !res_ready.
//    - On res_ready, clear res_valid and go to IDLE; res keeps its last value.
//  Timing:
//  - Feeds and pe_clr/pe_en are registered. Values for step t are present in the same cycle as pe_en for step t.
//  - Latency: res_valid rises on edge 1+(3N-2)+LAT after the accepting edge (9 for defaults).
//  - Throughput: one job per 3N+LAT+1 cycles with res_ready tied high.
//  - Step counter width is $clog2(3N); it never wraps inside FEED.
//  Arithmetic: operands pass through unchanged; there is no extension or saturation. Results are taken as presented (array wraps mod 2^ACC_W).
//  Changes to a_mat/b_mat after acceptance do not affect the running job.
// CONFIGURATION
//  SYSFEED_ABORT_EN defined:
//  - Adds input abort (1 bit).
//  - abort in CLEAR/FEED/DRAIN: the next state is FLUSH (1 cycle, pe_clr=1, pe_en=0, feeds 0), then IDLE.
//  - An aborted job never raises res_valid and leaves res unchanged.
//  - abort in IDLE/RESULT is ignored.
//  SYSFEED_ABORT_EN undefined: no abort port, no FLUSH state; every accepted job runs to RESULT.
// STRUCTURE
//  Package systolic_pkg:
//  - default N/DW/ACC_W constants.
//  - state enum (IDLE, CLEAR, FEED, DRAIN, RESULT, FLUSH).
//  - helper function elem(mat, r, c, DW).
//  Sub-module systolic_skew_sel:
//  - Given t and a latched matrix, produces one N*DW skewed edge vector.
//  - Instanced twice: A by rows; B by columns via a transpose flag.
// TESTING
//  1. N=3: A all 4, B all 1, res_ready=1 -> every res element = 12; res_valid 9 edges after accept.
//  2. A=[1..9] row-major, B=I -> at FEED t=2, a_feed rows {0,1,2} = {3,5,7}; res = A.
//  3. Wrap: A all 31, B all 1 -> every res element = 29 (93 mod 32).
//  4. Backpressure: res_ready=0 for 5 cycles with start pulsed each cycle -> res stable, start_ready=0; one job only.
//  5. Reset mid-FEED (t=3): rst_n low 2 cycles -> all outputs 0 at once, start_ready=1; next job gives correct res.
//  6. SYSFEED_ABORT_EN: abort at FEED t=1 -> one pe_clr cycle, then IDLE; res_valid never rises; res unchanged.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared constants, FSM state encoding and element-extraction helper for the
// systolic multiplier feed sequencer.
package systolic_pkg;

    localparam int N_DEF      = 3;
    localparam int DW_DEF     = 5;
    localparam int ACC_W_DEF  = 5;
    localparam int LAT_DEF    = 1;

    // Upper bounds for the generic element helper; packed matrices and
    // elements are zero-extended to these widths before extraction.
    localparam int MAT_MAX_W  = 1024;
    localparam int ELEM_MAX_W = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        FEED   = 3'd2,
        DRAIN  = 3'd3,
        RESULT = 3'd4,
        FLUSH  = 3'd5
    } state_t;

    // Element [r][c] of a row-major packed n x n matrix with dw-bit elements.
    function automatic logic [ELEM_MAX_W-1:0] elem(
        input logic [MAT_MAX_W-1:0] mat,
        input int                   r,
        input int                   c,
        input int                   dw,
        input int                   n = N_DEF
    );
        logic [MAT_MAX_W-1:0] sh;
        sh   = mat >> ((r * n + c) * dw);
        elem = '0;
        for (int b = 0; b < ELEM_MAX_W; b++) begin
            if (b < dw) elem[b] = sh[b];
        end
    endfunction

endpackage

// File: rtl/systolic_skew_sel.sv
// Skewed edge-vector selector: lane l carries the element whose inner index
// is t-l, or zero outside the wavefront. TRANSPOSE=0 walks rows of A
// (lane = row), TRANSPOSE=1 walks columns of B (lane = column).
module systolic_skew_sel
    import systolic_pkg::*;
#(
    parameter int N         = N_DEF,
    parameter int DW        = DW_DEF,
    parameter int TW        = 4,
    parameter bit TRANSPOSE = 1'b0
)(
    input  logic [TW-1:0]     t,
    input  logic [N*N*DW-1:0] mat,
    output logic [N*DW-1:0]   edge_vec
);

    logic [MAT_MAX_W-1:0] mat_ext;

    assign mat_ext = MAT_MAX_W'(mat);

    // One element per lane, selected by the diagonal wavefront position t.
    always_comb begin
        edge_vec = '0;
        for (int l = 0; l < N; l++) begin
            if ((int'(t) >= l) && ((int'(t) - l) < N)) begin
                edge_vec[l*DW +: DW] = DW'(elem(mat_ext,
                                                TRANSPOSE ? int'(t) - l : l,
                                                TRANSPOSE ? l : int'(t) - l,
                                                DW, N));
            end
        end
    end

endmodule

// File: rtl/systolic_feed_ctrl.sv
// Feed sequencer for an NxN output-stationary systolic multiplier.
// Optional build macro: SYSFEED_ABORT_EN adds an abort input and FLUSH state.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | waiting for start; operands latched on acceptance
//   CLEAR  | one cycle of pe_clr to zero the PE accumulators
//   FEED   | 3N-2 skewed feed steps, t = 0..3N-3, pe_en high
//   DRAIN  | LAT cycles of pe_en with zero feeds so the array settles
//   RESULT | res holds the captured array output until res_ready
//   FLUSH  | (abort build only) one pe_clr cycle after an abort, then IDLE
module systolic_feed_ctrl
    import systolic_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int DW    = DW_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int LAT   = LAT_DEF
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 start_ready,
    input  logic [N*N*DW-1:0]    a_mat,
    input  logic [N*N*DW-1:0]    b_mat,
    output logic                 pe_clr,
    output logic                 pe_en,
    output logic [N*DW-1:0]      a_feed,
    output logic [N*DW-1:0]      b_feed,
    input  logic [N*N*ACC_W-1:0] arr_res,
    output logic [N*N*ACC_W-1:0] res,
    output logic                 res_valid,
    input  logic                 res_ready,
`ifdef SYSFEED_ABORT_EN
    input  logic                 abort,
`endif
    output logic                 busy
);

    localparam int              TW         = $clog2(3 * N);
    localparam logic [TW-1:0]   STEP_LAST  = TW'(3 * N - 3);
    localparam int              DCW        = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [DCW-1:0]  DRAIN_INIT = DCW'(LAT - 1);

    state_t                 state_q, state_d;
    logic [TW-1:0]          step_q, step_d;
    logic [DCW-1:0]         drain_q, drain_d;
    logic [N*N*DW-1:0]      a_lat_q, a_lat_d;
    logic [N*N*DW-1:0]      b_lat_q, b_lat_d;
    logic                   pe_clr_q, pe_clr_d;
    logic                   pe_en_q, pe_en_d;
    logic [N*DW-1:0]        a_feed_q, a_feed_d;
    logic [N*DW-1:0]        b_feed_q, b_feed_d;
    logic [N*N*ACC_W-1:0]   res_q, res_d;
    logic                   res_valid_q, res_valid_d;
    logic [N*DW-1:0]        a_skew, b_skew;

    // Skew selectors look at the next step so the registered feeds line up
    // with the registered pe_en of the same step.
    systolic_skew_sel #(.N(N), .DW(DW), .TW(TW), .TRANSPOSE(1'b0)) u_skew_a (
        .t        (step_d),
        .mat      (a_lat_q),
        .edge_vec (a_skew)
    );

    systolic_skew_sel #(.N(N), .DW(DW), .TW(TW), .TRANSPOSE(1'b1)) u_skew_b (
        .t        (step_d),
        .mat      (b_lat_q),
        .edge_vec (b_skew)
    );

    // Next-state, operand latch, result capture and registered array controls.
    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        drain_d     = drain_q;
        a_lat_d     = a_lat_q;
        b_lat_d     = b_lat_q;
        res_d       = res_q;
        res_valid_d = res_valid_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_lat_d = a_mat;
                    b_lat_d = b_mat;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                step_d  = '0;
                state_d = FEED;
            end
            FEED: begin
                if (step_q == STEP_LAST) begin
                    drain_d = DRAIN_INIT;
                    state_d = DRAIN;
                end else begin
                    step_d = step_q + 1'b1;
                end
            end
            DRAIN: begin
                if (drain_q == '0) begin
                    res_d       = arr_res;
                    res_valid_d = 1'b1;
                    state_d     = RESULT;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            RESULT: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            FLUSH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef SYSFEED_ABORT_EN
        // An aborted job must not publish anything, even on the DRAIN exit.
        if (abort && ((state_q == CLEAR) || (state_q == FEED) || (state_q == DRAIN))) begin
            state_d     = FLUSH;
            res_d       = res_q;
            res_valid_d = res_valid_q;
        end
`endif

        pe_clr_d = (state_d == CLEAR) || (state_d == FLUSH);
        pe_en_d  = (state_d == FEED)  || (state_d == DRAIN);
        a_feed_d = (state_d == FEED) ? a_skew : '0;
        b_feed_d = (state_d == FEED) ? b_skew : '0;
    end

    // State and datapath registers; reset discards any job in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            step_q      <= '0;
            drain_q     <= '0;
            a_lat_q     <= '0;
            b_lat_q     <= '0;
            pe_clr_q    <= 1'b0;
            pe_en_q     <= 1'b0;
            a_feed_q    <= '0;
            b_feed_q    <= '0;
            res_q       <= '0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            drain_q     <= drain_d;
            a_lat_q     <= a_lat_d;
            b_lat_q     <= b_lat_d;
            pe_clr_q    <= pe_clr_d;
            pe_en_q     <= pe_en_d;
            a_feed_q    <= a_feed_d;
            b_feed_q    <= b_feed_d;
            res_q       <= res_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign start_ready = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign pe_clr      = pe_clr_q;
    assign pe_en       = pe_en_q;
    assign a_feed      = a_feed_q;
    assign b_feed      = b_feed_q;
    assign res         = res_q;
    assign res_valid   = res_valid_q;

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Bench for systolic_feed_ctrl: a simple register-passing MAC array model
// closes the loop on arr_res; results are compared against a direct matrix
// product and feeds against the diagonal wavefront formula.
module tb_systolic_feed_ctrl;

    localparam int N     = 3;
    localparam int DW    = 5;
    localparam int ACC_W = 5;
    localparam int LAT   = 1;
    localparam int MW    = N * N * DW;
    localparam int RW    = N * N * ACC_W;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          start_ready;
    logic [MW-1:0] a_mat, b_mat;
    logic          pe_clr, pe_en;
    logic [N*DW-1:0] a_feed, b_feed;
    logic [RW-1:0] arr_res;
    logic [RW-1:0] res;
    logic          res_valid;
    logic          res_ready;
    logic          busy;
`ifdef SYSFEED_ABORT_EN
    logic          abort;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic [RW-1:0] last_res;

    systolic_feed_ctrl #(.N(N), .DW(DW), .ACC_W(ACC_W), .LAT(LAT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .start_ready (start_ready),
        .a_mat       (a_mat),
        .b_mat       (b_mat),
        .pe_clr      (pe_clr),
        .pe_en       (pe_en),
        .a_feed      (a_feed),
        .b_feed      (b_feed),
        .arr_res     (arr_res),
        .res         (res),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
`ifdef SYSFEED_ABORT_EN
        .abort       (abort),
`endif
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Array model: operands hop one PE per enabled cycle, each PE multiplies
    // what arrives and accumulates modulo 2^ACC_W.
    logic [ACC_W-1:0] acc [N][N];
    logic [DW-1:0]    ar  [N][N];
    logic [DW-1:0]    br  [N][N];

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (!rst_n || pe_clr) begin
                    acc[i][j] <= '0;
                    ar[i][j]  <= '0;
                    br[i][j]  <= '0;
                end else if (pe_en) begin
                    ar[i][j]  <= (j == 0) ? a_feed[i*DW +: DW] : ar[i][(j == 0) ? 0 : j-1];
                    br[i][j]  <= (i == 0) ? b_feed[j*DW +: DW] : br[(i == 0) ? 0 : i-1][j];
                    acc[i][j] <= acc[i][j] + ACC_W'(
                        int'((j == 0) ? a_feed[i*DW +: DW] : ar[i][(j == 0) ? 0 : j-1]) *
                        int'((i == 0) ? b_feed[j*DW +: DW] : br[(i == 0) ? 0 : i-1][j]));
                end
            end
        end
    end

    always_comb begin
        arr_res = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                arr_res[(i*N+j)*ACC_W +: ACC_W] = acc[i][j];
    end

    function automatic logic [RW-1:0] matmul(input logic [MW-1:0] a, input logic [MW-1:0] b);
        int s;
        matmul = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                s = 0;
                for (int k = 0; k < N; k++)
                    s += int'(a[(i*N+k)*DW +: DW]) * int'(b[(k*N+j)*DW +: DW]);
                matmul[(i*N+j)*ACC_W +: ACC_W] = ACC_W'(s);
            end
        end
    endfunction

    function automatic logic [N*DW-1:0] exp_a_feed(input logic [MW-1:0] a, input int t);
        exp_a_feed = '0;
        for (int i = 0; i < N; i++)
            if (t - i >= 0 && t - i < N)
                exp_a_feed[i*DW +: DW] = a[(i*N + (t-i))*DW +: DW];
    endfunction

    function automatic logic [N*DW-1:0] exp_b_feed(input logic [MW-1:0] b, input int t);
        exp_b_feed = '0;
        for (int j = 0; j < N; j++)
            if (t - j >= 0 && t - j < N)
                exp_b_feed[j*DW +: DW] = b[((t-j)*N + j)*DW +: DW];
    endfunction

    function automatic logic [MW-1:0] mat_fill(input int v);
        mat_fill = '0;
        for (int e = 0; e < N*N; e++) mat_fill[e*DW +: DW] = DW'(v);
    endfunction

    function automatic logic [MW-1:0] rnd_mat();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[MW-1:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one job; hold>0 keeps res_ready low (with start spam) for that many
    // cycles; rst_at>=0 pulls reset after that feed step and abandons the job.
    task automatic run_job(input logic [MW-1:0] a, input logic [MW-1:0] b,
                           input int hold, input int rst_at);
        logic [RW-1:0] exp;
        exp = matmul(a, b);
        @(negedge clk);
        chk("idle_ready", 64'(start_ready), 64'd1);
        a_mat = a; b_mat = b; start = 1'b1; res_ready = (hold == 0);
        @(posedge clk); #1;
        start = 1'b0;
        a_mat = rnd_mat(); b_mat = rnd_mat();
        chk("clear_ctl", 64'({pe_clr, pe_en, busy, start_ready}), 64'b1010);
        chk("clear_feed", 64'({a_feed, b_feed}), 64'd0);
        for (int t = 0; t <= 3*N-3; t++) begin
            @(posedge clk); #1;
            chk("feed_ctl", 64'({pe_clr, pe_en, res_valid}), 64'b010);
            chk("a_feed", 64'(a_feed), 64'(exp_a_feed(a, t)));
            chk("b_feed", 64'(b_feed), 64'(exp_b_feed(b, t)));
            if (t == rst_at) begin
                @(negedge clk); rst_n = 1'b0; #1;
                chk("rst_outs", 64'({pe_clr, pe_en, a_feed, b_feed, res_valid, busy}), 64'd0);
                chk("rst_res", 64'(res), 64'd0);
                chk("rst_ready", 64'(start_ready), 64'd1);
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                last_res = '0;
                return;
            end
        end
        for (int d = 0; d < LAT; d++) begin
            @(posedge clk); #1;
            chk("drain_ctl", 64'({pe_clr, pe_en, res_valid}), 64'b010);
            chk("drain_feed", 64'({a_feed, b_feed}), 64'd0);
        end
        @(posedge clk); #1;
        chk("res_valid_rise", 64'({res_valid, busy, pe_en}), 64'b110);
        chk("res", 64'(res), 64'(exp));
        last_res = exp;
        for (int h = 0; h < hold; h++) begin
            start = 1'b1;
            @(posedge clk); #1;
            chk("hold_res", 64'(res), 64'(exp));
            chk("hold_ctl", 64'({res_valid, start_ready}), 64'b10);
        end
        start = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        chk("release", 64'({res_valid, start_ready, busy}), 64'b010);
        chk("res_kept", 64'(res), 64'(exp));
        if (hold > 0) begin
            @(posedge clk); #1;
            chk("single_job", 64'({pe_clr, start_ready}), 64'b01);
        end
    endtask

`ifdef SYSFEED_ABORT_EN
    task automatic abort_job(input logic [MW-1:0] a, input logic [MW-1:0] b, input int abort_t);
        @(negedge clk);
        a_mat = a; b_mat = b; start = 1'b1; res_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int t = 0; t <= abort_t; t++) begin
            @(posedge clk); #1;
            chk("ab_a_feed", 64'(a_feed), 64'(exp_a_feed(a, t)));
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("flush_ctl", 64'({pe_clr, pe_en, busy}), 64'b101);
        chk("flush_feed", 64'({a_feed, b_feed}), 64'd0);
        @(posedge clk); #1;
        chk("ab_idle", 64'({start_ready, busy, pe_clr, pe_en}), 64'b1000);
        for (int c = 0; c < 4; c++) begin
            chk("ab_no_valid", 64'(res_valid), 64'd0);
            chk("ab_res_kept", 64'(res), 64'(last_res));
            @(posedge clk); #1;
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [MW-1:0] a, b;
        rst_n = 1'b0; start = 1'b0; res_ready = 1'b0;
        a_mat = '0; b_mat = '0; last_res = '0;
`ifdef SYSFEED_ABORT_EN
        abort = 1'b0;
`endif
        #1;
        chk("reset_outs", 64'({pe_clr, pe_en, a_feed, b_feed, res_valid, busy}), 64'd0);
        chk("reset_res", 64'(res), 64'd0);
        chk("reset_ready", 64'(start_ready), 64'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_job(mat_fill(4), mat_fill(1), 0, -1);
        chk("all4_c00", 64'(res[ACC_W-1:0]), 64'd12);

        for (int e = 0; e < N*N; e++) a[e*DW +: DW] = DW'(e + 1);
        b = '0;
        for (int d = 0; d < N; d++) b[(d*N+d)*DW +: DW] = DW'(1);
        run_job(a, b, 0, -1);
        chk("ident_res", 64'(res), 64'(a));

        run_job(mat_fill(31), mat_fill(1), 0, -1);
        chk("wrap_c22", 64'(res[RW-1 -: ACC_W]), 64'd29);

        run_job(rnd_mat(), rnd_mat(), 5, -1);
        run_job(rnd_mat(), rnd_mat(), 0, 3);
        run_job(rnd_mat(), rnd_mat(), 0, -1);

`ifdef SYSFEED_ABORT_EN
        abort_job(rnd_mat(), rnd_mat(), 1);
        run_job(rnd_mat(), rnd_mat(), 0, -1);
`endif

        for (int j = 0; j < 20; j++)
            run_job(rnd_mat(), rnd_mat(), int'($urandom_range(0, 3)), -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
